// File: rtl/sram_o_ctrl_pkg.sv
// Shared definitions for the output-SRAM controller: size defaults, FSM states
// and the saturating add used on the accumulate write-back path.
package sram_o_ctrl_pkg;

  localparam int WORDS_DEF = 6272;
  localparam int DW_DEF    = 18;
  localparam int AW_DEF    = $clog2(WORDS_DEF) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACC_RD,
    ACC_WB,
    HRD_RD,
    HRD_RSP
  } state_e;

  localparam logic RR_ACC = 1'b0;
  localparam logic RR_HRD = 1'b1;

  // Operands arrive sign-extended to 32 bits; the result is clamped to a
  // w-bit signed range, so callers keep only the low w bits.
  function automatic logic signed [31:0] sat_add_f(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned       w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add_f = hi[31:0];
    end else if (sum < lo) begin
      sat_add_f = lo[31:0];
    end else begin
      sat_add_f = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/sram_o_ctrl_if.sv
// Request/response and SRAM-side signals of the output-SRAM controller.
// The slave modport is the controller; master is its environment.
interface sram_o_ctrl_if
  import sram_o_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic                 clr_start;
  logic                 clr_busy;

  logic                 acc_valid;
  logic                 acc_ready;
  logic [AW-1:0]        acc_addr;
  logic signed [DW-1:0] acc_data;

  logic                 rd_valid;
  logic                 rd_ready;
  logic [AW-1:0]        rd_addr;

  logic                 rsp_valid;
  logic signed [DW-1:0] rsp_data;

  logic                 addr_err;

  logic                 sram_we;
  logic [AW-1:0]        sram_addr;
  logic signed [DW-1:0] sram_din;
  logic signed [DW-1:0] sram_dout;

  modport slave (
    input  clr_start, acc_valid, acc_addr, acc_data, rd_valid, rd_addr, sram_dout,
    output clr_busy, acc_ready, rd_ready, rsp_valid, rsp_data, addr_err,
           sram_we, sram_addr, sram_din
  );

  modport master (
    output clr_start, acc_valid, acc_addr, acc_data, rd_valid, rd_addr, sram_dout,
    input  clr_busy, acc_ready, rd_ready, rsp_valid, rsp_data, addr_err,
           sram_we, sram_addr, sram_din
  );

endinterface

// File: rtl/sram_o_ctrl_sat_add.sv
// Combinational DW-bit signed adder that clamps instead of wrapping.
module sat_add
  import sram_o_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] sum_o
);

  assign sum_o = DW'(sat_add_f(32'(a_i), 32'(b_i), DW));

endmodule

// File: rtl/sram_o_ctrl.sv
// Output-SRAM controller: zero-fill, read-modify-write accumulate from the conv
// engine and host readout, serialised through one FSM onto a single SRAM port.
module sram_o_ctrl
  import sram_o_ctrl_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = $clog2(WORDS) + 1
) (
  input logic          clk,
  input logic          rst,
  sram_o_ctrl_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
  localparam logic [AW-1:0] WORDS_A   = AW'(WORDS);

  state_e               state_q;
  logic                 rr_q;
  logic                 clr_pend_q;
  logic                 clr_busy_q;
  logic                 addr_err_q;
  logic                 in_range_q;
  logic                 sram_we_q;
  logic                 rsp_valid_q;
  logic [AW-1:0]        clr_cnt_q;
  logic [AW-1:0]        clr_cnt_d;
  logic [AW-1:0]        sram_addr_q;
  logic signed [DW-1:0] data_q;
  logic signed [DW-1:0] wb_sum;

  logic idle;
  logic clr_req;
  logic acc_in_range;
  logic rd_in_range;
  logic grant_acc;
  logic grant_rd;

  // Readies are gated by rst so they drop the instant reset is applied.
  assign idle         = (state_q == IDLE) && !rst;
  assign clr_req      = clr_pend_q || bus.clr_start;
  assign acc_in_range = bus.acc_addr < WORDS_A;
  assign rd_in_range  = bus.rd_addr < WORDS_A;
  assign grant_acc    = idle && !clr_req && bus.acc_valid &&
                        ((rr_q == RR_ACC) || !bus.rd_valid);
  assign grant_rd     = idle && !clr_req && bus.rd_valid &&
                        ((rr_q == RR_HRD) || !bus.acc_valid);
  assign clr_cnt_d    = clr_cnt_q + 1'b1;

  sat_add #(.DW(DW)) u_sat_add (
    .a_i   (bus.sram_dout),
    .b_i   (data_q),
    .sum_o (wb_sum)
  );

  // Write data and response data come straight off the registered SRAM output,
  // which is valid exactly in ACC_WB / HRD_RSP.
  assign bus.sram_din  = (state_q == ACC_WB && in_range_q) ? wb_sum : '0;
  assign bus.rsp_data  = (state_q == HRD_RSP && in_range_q) ? bus.sram_dout : '0;
  assign bus.acc_ready = grant_acc;
  assign bus.rd_ready  = grant_rd;
  assign bus.sram_we   = sram_we_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.addr_err  = addr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= RR_ACC;
      clr_pend_q  <= 1'b0;
      clr_busy_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      in_range_q  <= 1'b0;
      sram_we_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      clr_cnt_q   <= '0;
      sram_addr_q <= '0;
      data_q      <= '0;
    end else begin
      if (bus.clr_start && state_q != IDLE && state_q != CLEAR) begin
        clr_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          sram_we_q   <= 1'b0;
          sram_addr_q <= '0;
          rsp_valid_q <= 1'b0;
          if (clr_req) begin
            state_q     <= CLEAR;
            clr_pend_q  <= 1'b0;
            clr_busy_q  <= 1'b1;
            clr_cnt_q   <= '0;
            sram_we_q   <= 1'b1;
            sram_addr_q <= '0;
          end else if (grant_acc) begin
            state_q     <= ACC_RD;
            rr_q        <= ~rr_q;
            data_q      <= bus.acc_data;
            in_range_q  <= acc_in_range;
            sram_addr_q <= acc_in_range ? bus.acc_addr : '0;
            if (!acc_in_range) begin
              addr_err_q <= 1'b1;
            end
          end else if (grant_rd) begin
            state_q     <= HRD_RD;
            rr_q        <= ~rr_q;
            in_range_q  <= rd_in_range;
            sram_addr_q <= rd_in_range ? bus.rd_addr : '0;
            if (!rd_in_range) begin
              addr_err_q <= 1'b1;
            end
          end
        end

        CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q     <= IDLE;
            clr_busy_q  <= 1'b0;
            clr_cnt_q   <= '0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
          end else begin
            clr_cnt_q   <= clr_cnt_d;
            sram_addr_q <= clr_cnt_d;
          end
        end

        // Address stays on the bus for the write-back; an out-of-range
        // request never raises the write enable.
        ACC_RD: begin
          state_q   <= ACC_WB;
          sram_we_q <= in_range_q;
        end

        ACC_WB: begin
          state_q     <= IDLE;
          sram_we_q   <= 1'b0;
          sram_addr_q <= '0;
        end

        HRD_RD: begin
          state_q     <= HRD_RSP;
          rsp_valid_q <= 1'b1;
          sram_addr_q <= '0;
        end

        HRD_RSP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          sram_we_q   <= 1'b0;
          sram_addr_q <= '0;
          rsp_valid_q <= 1'b0;
          clr_busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
